// File: rtl/bus_arbiter_lv1_lv2_if.sv
// rtl/bus_arbiter_lv1_lv2_if.sv - lv1/lv2 bus request/grant bundle between the cores and the arbiter
interface bus_arbiter_lv1_lv2_if;
    logic [3:0] bus_lv1_lv2_req_proc;
    logic [3:0] bus_lv1_lv2_req_snoop;
    logic [3:0] bus_lv1_lv2_gnt_proc;
    logic [3:0] bus_lv1_lv2_gnt_snoop;
    logic [1:0] arb_owner;
    logic       arb_busy;
    logic       arb_timeout;

    modport master (
        output bus_lv1_lv2_req_proc,
        output bus_lv1_lv2_req_snoop,
        input  bus_lv1_lv2_gnt_proc,
        input  bus_lv1_lv2_gnt_snoop,
        input  arb_owner,
        input  arb_busy,
        input  arb_timeout
    );

    modport slave (
        input  bus_lv1_lv2_req_proc,
        input  bus_lv1_lv2_req_snoop,
        output bus_lv1_lv2_gnt_proc,
        output bus_lv1_lv2_gnt_snoop,
        output arb_owner,
        output arb_busy,
        output arb_timeout
    );
endinterface

// File: rtl/bus_arbiter_lv1_lv2.sv
// rtl/bus_arbiter_lv1_lv2.sv - 4-core round-robin processor/snoop bus arbiter, optional watchdog via ARB_WATCHDOG_EN
module bus_arbiter_lv1_lv2 #(
    parameter int unsigned WDOG_LIMIT = 255,
    parameter int unsigned WDOG_WID   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bus_arbiter_lv1_lv2_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROC  = 2'd1,
        ST_SNOOP = 2'd2
    } state_t;

    if (WDOG_LIMIT > (2 ** WDOG_WID) - 1) begin : g_wdog_limit_check
        $error("WDOG_LIMIT does not fit in WDOG_WID bits");
    end

    state_t     r_state;
    logic [1:0] r_owner;
    logic [1:0] r_snoop_idx;
    logic [1:0] r_rr_ptr;
    logic [3:0] r_gnt_proc;
    logic [3:0] r_gnt_snoop;
    logic [1:0] r_arb_owner;
    logic       r_arb_busy;
    logic       r_arb_timeout;

    state_t     w_next_state;
    logic [1:0] w_next_owner;
    logic [1:0] w_next_snoop_idx;
    logic [1:0] w_next_rr_ptr;
    logic [3:0] w_gnt_proc_nxt;
    logic [3:0] w_gnt_snoop_nxt;
    logic [1:0] w_arb_owner_nxt;
    logic       w_arb_busy_nxt;
    logic       w_arb_timeout_nxt;

    logic [2:0] w_proc_pick;
    logic [2:0] w_snoop_pick;
    logic [3:0] w_snoop_cand;
    logic       w_owner_req;
    logic       w_snoop_req;
    logic       w_wdog_fire;

    // Returns {found, index} of the first set bit scanning upward from start with wrap.
    function automatic logic [2:0] f_rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    // The owner's own snoop request is never eligible.
    assign w_snoop_cand = bus.bus_lv1_lv2_req_snoop & ~(4'b0001 << r_owner);
    assign w_proc_pick  = f_rr_pick(bus.bus_lv1_lv2_req_proc, r_rr_ptr + 2'd1);
    assign w_snoop_pick = f_rr_pick(w_snoop_cand, r_owner + 2'd1);
    assign w_owner_req  = bus.bus_lv1_lv2_req_proc[r_owner];
    assign w_snoop_req  = bus.bus_lv1_lv2_req_snoop[r_snoop_idx];

`ifdef ARB_WATCHDOG_EN
    localparam logic [WDOG_WID-1:0] LP_WDOG_LIMIT = WDOG_LIMIT[WDOG_WID-1:0];

    logic [WDOG_WID-1:0] r_wdog_cnt;

    assign w_wdog_fire = (r_state != ST_IDLE) && (r_wdog_cnt == LP_WDOG_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog_cnt <= '0;
        end else if (r_state == ST_IDLE || w_wdog_fire) begin
            r_wdog_cnt <= '0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end
`else
    assign w_wdog_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_owner       <= 2'd0;
            r_snoop_idx   <= 2'd0;
            r_rr_ptr      <= 2'd3;
            r_gnt_proc    <= 4'b0000;
            r_gnt_snoop   <= 4'b0000;
            r_arb_owner   <= 2'd0;
            r_arb_busy    <= 1'b0;
            r_arb_timeout <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_owner       <= w_next_owner;
            r_snoop_idx   <= w_next_snoop_idx;
            r_rr_ptr      <= w_next_rr_ptr;
            r_gnt_proc    <= w_gnt_proc_nxt;
            r_gnt_snoop   <= w_gnt_snoop_nxt;
            r_arb_owner   <= w_arb_owner_nxt;
            r_arb_busy    <= w_arb_busy_nxt;
            r_arb_timeout <= w_arb_timeout_nxt;
        end
    end

    // Release of the processor owner wins over a pending snoop in PROC; in SNOOP the release is deferred.
    always_comb begin
        w_next_state     = r_state;
        w_next_owner     = r_owner;
        w_next_snoop_idx = r_snoop_idx;
        w_next_rr_ptr    = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_proc_pick[2]) begin
                    w_next_state = ST_PROC;
                    w_next_owner = w_proc_pick[1:0];
                end
            end
            ST_PROC: begin
                if (w_wdog_fire || !w_owner_req) begin
                    w_next_state  = ST_IDLE;
                    w_next_rr_ptr = r_owner;
                end else if (w_snoop_pick[2]) begin
                    w_next_state     = ST_SNOOP;
                    w_next_snoop_idx = w_snoop_pick[1:0];
                end
            end
            ST_SNOOP: begin
                if (w_wdog_fire) begin
                    w_next_state  = ST_IDLE;
                    w_next_rr_ptr = r_owner;
                end else if (!w_snoop_req) begin
                    w_next_state = ST_PROC;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_gnt_proc_nxt    = 4'b0000;
        w_gnt_snoop_nxt   = 4'b0000;
        w_arb_owner_nxt   = 2'd0;
        w_arb_busy_nxt    = 1'b0;
        w_arb_timeout_nxt = w_wdog_fire;
        if (w_next_state != ST_IDLE) begin
            w_gnt_proc_nxt  = 4'b0001 << w_next_owner;
            w_arb_owner_nxt = w_next_owner;
            w_arb_busy_nxt  = 1'b1;
        end
        if (w_next_state == ST_SNOOP) begin
            w_gnt_snoop_nxt = 4'b0001 << w_next_snoop_idx;
        end
    end

    assign bus.bus_lv1_lv2_gnt_proc  = r_gnt_proc;
    assign bus.bus_lv1_lv2_gnt_snoop = r_gnt_snoop;
    assign bus.arb_owner             = r_arb_owner;
    assign bus.arb_busy              = r_arb_busy;
    assign bus.arb_timeout           = r_arb_timeout;

endmodule

// File: tb/tb_bus_arbiter_lv1_lv2.sv
// tb/tb_bus_arbiter_lv1_lv2.sv - self-checking bench for bus_arbiter_lv1_lv2
module tb_bus_arbiter_lv1_lv2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bus_arbiter_lv1_lv2_if u_bus();

    bus_arbiter_lv1_lv2 #(
        .WDOG_LIMIT (4),
        .WDOG_WID   (8)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus)
    );

    typedef struct {
        logic       rst;
        logic [3:0] rp;
        logic [3:0] rs;
        logic [3:0] gp;
        logic [3:0] gs;
        logic [1:0] own;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   run_done = 1'b0;

    function automatic vec_t mk(input logic r, input logic [3:0] rp, input logic [3:0] rs,
                                input logic [3:0] gp, input logic [3:0] gs, input logic [1:0] own,
                                input logic busy, input logic to);
        vec_t v;
        v.rst = r; v.rp = rp; v.rs = rs; v.gp = gp; v.gs = gs;
        v.own = own; v.busy = busy; v.to = to;
        return v;
    endfunction

    task automatic check_out(input string tag);
        vec_t       e;
        logic [12:0] act;
        logic [12:0] want;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e    = exp_q.pop_front();
            act  = {u_bus.bus_lv1_lv2_gnt_proc, u_bus.bus_lv1_lv2_gnt_snoop, u_bus.arb_owner,
                    u_bus.arb_busy, u_bus.arb_timeout};
            want = {e.gp, e.gs, e.own, e.busy, e.to};
            if (act !== want) begin
                n_bad++;
                $display("FAIL %s: got gp=%b gs=%b own=%0d busy=%b to=%b, want gp=%b gs=%b own=%0d busy=%b to=%b",
                         tag, act[12:9], act[8:5], act[4:3], act[2], act[1],
                         e.gp, e.gs, e.own, e.busy, e.to);
            end
        end
    endtask

    // Called just after a falling edge: drive, queue the expectation, compare after the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        rst = v.rst;
        u_bus.bus_lv1_lv2_req_proc  = v.rp;
        u_bus.bus_lv1_lv2_req_snoop = v.rs;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_out(tag);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!run_done) begin
            n_cmp++;
            if (!($onehot0(u_bus.bus_lv1_lv2_gnt_proc) && $onehot0(u_bus.bus_lv1_lv2_gnt_snoop) &&
                  ((u_bus.bus_lv1_lv2_gnt_proc & u_bus.bus_lv1_lv2_gnt_snoop) == 4'b0000))) begin
                n_bad++;
                $display("FAIL grant_exclusive: got gp=%b gs=%b, want one-hot-or-zero and disjoint",
                         u_bus.bus_lv1_lv2_gnt_proc, u_bus.bus_lv1_lv2_gnt_snoop);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        //                 rst   rp       rs       gp       gs      own busy to
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        // all four cores contend; each owner holds three cycles then releases
        tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        // owner 1 with snoops from cores 1 and 2: only core 2 served
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0110, 4'b0010, 4'b0100, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0110, 4'b0010, 4'b0100, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        // owner 2 drops its request while core 3 holds a snoop grant
        tbl.push_back(mk(1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0100, 4'b1001, 4'b0100, 4'b1000, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b1001, 4'b0100, 4'b1000, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0001, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        // reset during SNOOP, then core 3 alone
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        // snoop requests alone are ignored in IDLE
        tbl.push_back(mk(1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // rr_ptr is 3 here, so core 0 wins the hold test
`ifdef ARB_WATCHDOG_EN
        apply(mk(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0), "wdog_grant");
        for (int i = 1; i <= 4; i++) begin
            apply(mk(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0), $sformatf("wdog_hold%0d", i));
        end
        apply(mk(1'b0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1), "wdog_fire");
        apply(mk(1'b0, 4'b0011, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0), "wdog_next_core1");
        apply(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0), "wdog_release");
`else
        apply(mk(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0), "hold_grant");
        for (int i = 1; i <= 10; i++) begin
            apply(mk(1'b0, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0), $sformatf("hold%0d", i));
        end
        apply(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0), "hold_release");
`endif

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end
        run_done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_lv1_lv2.md
BUS_ARBITER_LV1_LV2 -- requirements
Module: bus_arbiter_lv1_lv2

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Parameter WDOG_LIMIT, default 255: cycles a grant may be held before forced release.
REQ-003 Parameter WDOG_WID, default 8: watchdog counter width; WDOG_LIMIT SHALL be at most 2^WDOG_WID-1.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 bus_lv1_lv2_req_proc  input  4  per-core processor-side bus request from lv1.
REQ-007 bus_lv1_lv2_req_snoop  input  4  per-core snoop-response bus request from lv1.
REQ-008 bus_lv1_lv2_gnt_proc  output  4  one-hot-or-zero processor grant.
REQ-009 bus_lv1_lv2_gnt_snoop  output  4  one-hot-or-zero snoop grant.
REQ-010 arb_owner  output  2  index of the current processor-grant owner; 0 when idle.
REQ-011 arb_busy  output  1  high whenever any grant is asserted.
REQ-012 arb_timeout  output  1  one-cycle pulse on watchdog forced release.

Function
REQ-013 States SHALL be IDLE, PROC and SNOOP; all outputs SHALL be registered.
REQ-014 IDLE: if any req_proc bit is high, grant the first requester in round-robin order starting at rr_ptr+1 (mod 4).
  - gnt_proc SHALL assert in the cycle after req_proc is sampled, giving 1-cycle latency.
  - The state SHALL then move to PROC.
REQ-015 IDLE: req_snoop SHALL be ignored and gnt_snoop SHALL stay 0.
REQ-016 PROC: gnt_proc[owner] SHALL stay high while req_proc[owner] is high.
  - When req_proc[owner] is sampled low, gnt_proc SHALL drop the next cycle.
  - rr_ptr SHALL be set to owner and the state SHALL return to IDLE.
  - Re-arbitration SHALL occur only from IDLE (minimum one idle cycle between processor owners).
REQ-017 PROC: if any req_snoop[i] with i != owner is high, grant the first such i in round-robin order starting at owner+1.
  - gnt_snoop[i] SHALL assert the next cycle and the state SHALL move to SNOOP.
  - gnt_proc[owner] SHALL remain high.
REQ-018 req_snoop[owner] SHALL never be granted.
REQ-019 SNOOP: gnt_snoop[i] SHALL stay high while req_snoop[i] is high.
  - On deassert, gnt_snoop SHALL drop the next cycle and the state SHALL return to PROC.
  - Further snoop requests SHALL be served one at a time through PROC.
REQ-020 SNOOP: a drop of req_proc[owner] SHALL be deferred; gnt_proc[owner] SHALL stay high until the snoop releases, then PROC SHALL apply REQ-016.
REQ-021 Simultaneous processor requests SHALL resolve strictly by rr_ptr, and no core SHALL be granted twice while another core requests continuously.
REQ-022 At most one gnt_proc bit and at most one gnt_snoop bit SHALL be high in any cycle, and they SHALL never share an index.

Reset
REQ-023 While rst is high, the following SHALL hold at the next edge:
  - state IDLE;
  - gnt_proc = 0, gnt_snoop = 0;
  - arb_owner = 0, arb_busy = 0, arb_timeout = 0;
  - rr_ptr = 3, so core 0 wins first;
  - watchdog count = 0.
REQ-024 Reset asserted mid-PROC or mid-SNOOP SHALL drop all grants at the next edge regardless of requests.

Configuration
REQ-025 Macro ARB_WATCHDOG_EN defined: a WDOG_WID counter SHALL count cycles spent in PROC or SNOOP and clear in IDLE.
  - When the count reaches WDOG_LIMIT, all grants SHALL drop the next cycle.
  - rr_ptr SHALL be set to owner and the state SHALL go to IDLE.
  - arb_timeout SHALL pulse for exactly one cycle.
REQ-026 Macro ARB_WATCHDOG_EN undefined: no counter SHALL exist, arb_timeout SHALL be constant 0, and grants SHALL be held indefinitely.

Verification
REQ-027 Post-reset, req_proc=4'b0001 -> gnt_proc=4'b0001 one cycle later, arb_owner=0, arb_busy=1.
REQ-028 req_proc=4'b1111 held, each owner releasing after 3 cycles -> grant order 0,1,2,3,0 with one idle cycle between owners.
REQ-029 Owner 1 in PROC, req_snoop=4'b0110 -> gnt_snoop=4'b0100 next cycle, then 4'b0000 after release, and core 1 is never snoop-granted.
REQ-030 Owner 2 drops req_proc during SNOOP on core 3 -> gnt_proc=4'b0100 held until gnt_snoop drops, then 4'b0000.
REQ-031 ARB_WATCHDOG_EN with WDOG_LIMIT=4, req_proc[0] held -> grant dropped 5 cycles after assertion, arb_timeout pulses once, core 1 wins next if requesting.
REQ-032 rst asserted during SNOOP -> all outputs 0 at the next edge, and req_proc=4'b1000 afterwards -> core 3 granted.
